// File: rtl/bitcount_arbiter.sv
// bitcount_arbiter
// Shares one bit-count unit (clz / ctz / cpop) between two issue lanes.
// Requests from the two lanes are arbitrated round-robin, the accepted
// request is captured in stage S1, its count is computed from S1 and
// registered in stage S2, and S2 drives the response port directly.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of everything in flight
//   reqN_valid/ready      lane N request handshake (N = 0, 1)
//   reqN_op               00 clz, 01 ctz, 10 cpop, 11 reserved (result 0)
//   reqN_src              32-bit operand
//   reqN_tag              destination tag, returned with the result
//   rsp_valid/ready       response handshake
//   rsp_lane/tag/data     originating lane, tag and count (0..32)
module bitcount_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_src,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_src,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_lane,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data
);

  // Stage S1: accepted request waiting for its count
  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [31:0]      r_s1_src;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_lane;

  // Stage S2: finished result presented on the response port
  logic             r_s2_valid;
  logic [31:0]      r_s2_data;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_lane;

  // Favoured lane when both lanes request in the same cycle
  logic             r_prio;

  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_s1_adv;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_found;
  logic [5:0]       w_cnt;
  logic [31:0]      w_result;

  assign w_s2_free = !r_s2_valid || rsp_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s2_free;

  // A lone requester always wins; on contention r_prio decides.
  assign w_grant0 = req0_valid && (!req1_valid || !r_prio);
  assign w_grant1 = req1_valid && (!req0_valid ||  r_prio);

  // Gated by rst_n so both readies read low while reset is asserted.
  assign req0_ready = rst_n && w_grant0 && w_s1_free && !flush;
  assign req1_ready = rst_n && w_grant1 && w_s1_free && !flush;
  assign w_accept   = req0_ready || req1_ready;

  // Count for the operation sitting in S1. The scan stops at the first
  // set bit for clz/ctz, so an all-zero operand naturally yields 32.
  always_comb begin
    w_cnt   = '0;
    w_found = 1'b0;
    case (r_s1_op)
      2'b00: begin
        for (int i = 31; i >= 0; i--) begin
          if (!w_found) begin
            if (r_s1_src[i]) w_found = 1'b1;
            else             w_cnt   = w_cnt + 6'd1;
          end
        end
      end
      2'b01: begin
        for (int i = 0; i < 32; i++) begin
          if (!w_found) begin
            if (r_s1_src[i]) w_found = 1'b1;
            else             w_cnt   = w_cnt + 6'd1;
          end
        end
      end
      2'b10: begin
        for (int i = 0; i < 32; i++) begin
          if (r_s1_src[i]) w_cnt = w_cnt + 6'd1;
        end
      end
      default: w_cnt = '0;
    endcase
    w_result = {26'd0, w_cnt};
  end

  // S1 loads the granted request; flush wins over any load or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_src   <= '0;
      r_s1_tag   <= '0;
      r_s1_lane  <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_lane  <= req1_ready;
      r_s1_op    <= req1_ready ? req1_op  : req0_op;
      r_s1_src   <= req1_ready ? req1_src : req0_src;
      r_s1_tag   <= req1_ready ? req1_tag : req0_tag;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 payload only changes on a load, which keeps rsp_* stable under
  // backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
      r_s2_lane  <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= w_result;
      r_s2_tag   <= r_s1_tag;
      r_s2_lane  <= r_s1_lane;
    end else if (rsp_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // After an accepted grant the other lane becomes favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_prio <= 1'b0;
    else if (w_accept) r_prio <= req0_ready;
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_lane  = r_s2_lane;
  assign rsp_tag   = r_s2_tag;
  assign rsp_data  = r_s2_data;

endmodule
